// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the Ibex fetch and LSU ports.
// Out-of-window requests are granted but answered with an error instead of touching the RAM.
module ram_port_arbiter #(
    parameter int unsigned AW        = 17,
    parameter int unsigned DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DW-1:0]     instr_rdata_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [DW/8-1:0]   data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [DW-1:0]     data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DW-1:0]     data_rdata_o,
    output logic              data_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_be_o,
    output logic [AW-3:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    typedef enum logic {PORT_INSTR, PORT_DATA} port_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;

    port_e  last_q, last_d;
    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   rd_q, rd_d;

    logic instr_in_win, data_in_win;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    assign instr_in_win = (instr_addr_i[31:AW] == BASE_ADDR[31:AW]);
    assign data_in_win  = (data_addr_i[31:AW]  == BASE_ADDR[31:AW]);

    // The losing side of a contention is whichever port was granted last.
    assign instr_gnt_o = instr_req_i && (!data_req_i || (last_q == PORT_DATA));
    assign data_gnt_o  = data_req_i && (!instr_req_i || (last_q == PORT_INSTR));

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = data_addr_i[AW-1:2];
        mem_wdata_o = '0;
        last_d      = last_q;
        owner_d     = OWN_NONE;
        err_d       = 1'b0;
        rd_d        = 1'b0;

        if (data_gnt_o) begin
            last_d      = PORT_DATA;
            owner_d     = OWN_DATA;
            err_d       = !data_in_win;
            rd_d        = data_in_win && !data_we_i;
            mem_req_o   = data_in_win;
            mem_we_o    = data_in_win && data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i[AW-1:2];
            mem_wdata_o = data_wdata_i;
        end else if (instr_gnt_o) begin
            last_d      = PORT_INSTR;
            owner_d     = OWN_INSTR;
            err_d       = !instr_in_win;
            rd_d        = instr_in_win;
            mem_req_o   = instr_in_win;
            mem_be_o    = '1;
            mem_addr_o  = instr_addr_i[AW-1:2];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= PORT_INSTR;
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Read data passes straight from the RAM in the response cycle; writes and errors return zero.
    assign instr_rvalid_o = (owner_q == OWN_INSTR);
    assign instr_err_o    = instr_rvalid_o && err_q;
    assign instr_rdata_o  = (instr_rvalid_o && rd_q) ? mem_rdata_i : '0;

    assign data_rvalid_o  = (owner_q == OWN_DATA);
    assign data_err_o     = data_rvalid_o && err_q;
    assign data_rdata_o   = (data_rvalid_o && rd_q) ? mem_rdata_i : '0;

endmodule
